// File: rtl/cv32e41p_fetch_queue.sv
// OBI instruction fetch engine: DEPTH-entry word FIFO, up to MAX_OUT outstanding requests, branch flush.
// Optional feature macro: CV32E41P_FETCH_ERR_EN (per-entry bus-error tag and fetch stall after an error).
module cv32e41p_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_i,
  input  logic                         branch_i,
  input  logic [31:0]                  branch_addr_i,
  output logic                         fetch_valid_o,
  input  logic                         fetch_ready_i,
  output logic [31:0]                  fetch_rdata_o,
  output logic [31:0]                  fetch_addr_o,
  output logic                         fetch_err_o,
  output logic                         instr_req_o,
  output logic [31:0]                  instr_addr_o,
  input  logic                         instr_gnt_i,
  input  logic                         instr_rvalid_i,
  input  logic [31:0]                  instr_rdata_i,
  input  logic                         instr_err_i,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_WAIT_GNT_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_addr, r_br_addr, r_raddr;
  logic [CW-1:0] r_out, r_flush, r_cnt;
  logic [PW-1:0] r_rd, r_wr;
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:0]   r_mem_addr [DEPTH];

  logic [31:0]   w_tgt;
  logic          w_gnt, w_rv, w_acc, w_empty, w_valid, w_pop, w_push, w_issue, w_stall;
  logic          w_err_acc, w_head_err;
  logic [CW-1:0] w_out_nxt, w_cnt_nxt;
  logic [CW:0]   w_credit;
  logic          w_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_unused = ^{branch_addr_i[1:0], instr_err_i};
  assign w_tgt    = {branch_addr_i[31:2], 2'b00};

  assign instr_req_o  = (r_state != S_IDLE);
  assign instr_addr_o = r_addr;
  assign busy_o       = instr_req_o | (r_out != '0);
  assign occupancy_o  = r_cnt;

  // A response with nothing outstanding is ignored so the counter cannot underflow.
  assign w_gnt   = instr_req_o & instr_gnt_i;
  assign w_rv    = instr_rvalid_i & (r_out != '0);
  assign w_acc   = w_rv & ~branch_i & (r_flush == '0);
  assign w_empty = (r_cnt == '0);
  assign w_valid = ~branch_i & (~w_empty | w_acc);
  assign w_pop   = w_valid & fetch_ready_i & ~w_empty;
  assign w_push  = w_acc & ~(w_empty & fetch_ready_i);

  assign w_out_nxt = r_out + CW'(w_gnt) - CW'(w_rv);
  assign w_cnt_nxt = branch_i ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));
  assign w_credit  = {1'b0, w_out_nxt} + {1'b0, w_cnt_nxt};

  // Credits are judged on next-cycle counts, since a new request becomes visible one cycle later.
  assign w_issue = req_i & ~branch_i & ~w_stall & (w_out_nxt < CW'(MAX_OUT))
                 & (w_credit < (CW+1)'(DEPTH));

`ifdef CV32E41P_FETCH_ERR_EN
  logic             r_err_stall;
  logic [DEPTH-1:0] r_mem_err;

  assign w_err_acc  = w_acc & instr_err_i;
  assign w_stall    = r_err_stall | w_err_acc;
  assign w_head_err = w_empty ? instr_err_i : r_mem_err[r_rd];

  always_ff @(posedge clk) begin
    if (rst || branch_i) r_err_stall <= 1'b0;
    else if (w_err_acc)  r_err_stall <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem_err[r_wr] <= instr_err_i;
  end
`else
  assign w_err_acc  = 1'b0;
  assign w_stall    = w_err_acc;
  assign w_head_err = 1'b0;
`endif

  // Head of queue: bypass straight from the bus when the FIFO is empty.
  assign fetch_valid_o = w_valid;
  assign fetch_rdata_o = w_valid ? (w_empty ? instr_rdata_i : r_mem_data[r_rd]) : 32'h0;
  assign fetch_addr_o  = w_valid ? (w_empty ? r_raddr : r_mem_addr[r_rd]) : 32'h0;
  assign fetch_err_o   = w_valid & w_head_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_nxt = S_WAIT_GNT;
      end
      S_WAIT_GNT: begin
        if (branch_i)         w_state_nxt = instr_gnt_i ? S_IDLE : S_WAIT_GNT_FLUSH;
        else if (instr_gnt_i) w_state_nxt = w_issue ? S_WAIT_GNT : S_IDLE;
      end
      S_WAIT_GNT_FLUSH: begin
        if (instr_gnt_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The request address is only retargeted when no request is pending or it is granted this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'h0;
      r_br_addr <= 32'h0;
      r_raddr   <= 32'h0;
      r_out     <= '0;
      r_flush   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      if (branch_i) begin
        r_raddr <= w_tgt;
        r_flush <= w_out_nxt;
        if (r_state == S_IDLE || instr_gnt_i) r_addr    <= w_tgt;
        else                                  r_br_addr <= w_tgt;
      end else begin
        r_flush <= r_flush + CW'(w_gnt && (r_state == S_WAIT_GNT_FLUSH))
                           - CW'(w_rv && (r_flush != '0));
        if (w_gnt) r_addr <= (r_state == S_WAIT_GNT_FLUSH) ? r_br_addr : r_addr + 32'd4;
        if (w_acc) r_raddr <= r_raddr + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || branch_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr] <= instr_rdata_i;
      r_mem_addr[r_wr] <= r_raddr;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_cnt == CW'(DEPTH))))
    else $error("fetch queue written while full");
`endif

endmodule

// File: tb/tb_cv32e41p_fetch_queue.sv
// Scoreboard bench for cv32e41p_fetch_queue: directed fetch scenarios against a simple OBI memory model.
module tb_cv32e41p_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, branch_i, fetch_ready_i, instr_gnt_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o, fetch_err_o, instr_req_o, busy_o;
  logic [31:0] fetch_rdata_o, fetch_addr_o, instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i  = 32'h0;
  logic        instr_err_i    = 1'b0;
  logic [2:0]  occupancy_o;

  typedef struct { logic [31:0] a; logic [31:0] d; logic e; } exp_t;
  typedef struct { logic [31:0] a; int due; } rsp_t;

  exp_t        exp_q[$];
  rsp_t        sq[$];
  logic [31:0] glog[$];
  int          pop_cyc[$];
  int          nvec = 0, nfail = 0, cyc = 0;
  logic        hold = 1'b0;
  logic [31:0] err_addr = 32'h1;

  cv32e41p_fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i), .fetch_rdata_o(fetch_rdata_o),
    .fetch_addr_o(fetch_addr_o), .fetch_err_o(fetch_err_o), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .busy_o(busy_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: grants seen at the falling edge are answered one cycle after the grant edge.
  always begin
    @(negedge clk);
    if (rst) sq.delete();
    else if (instr_req_o && instr_gnt_i) begin
      sq.push_back('{a: instr_addr_o, due: cyc + 1});
      glog.push_back(instr_addr_o);
    end
    @(posedge clk); #1;
    cyc++;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    instr_err_i    = 1'b0;
    if (!hold && sq.size() != 0 && sq[0].due <= cyc) begin
      rsp_t r;
      r = sq.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(r.a);
      instr_err_i    = (r.a == err_addr);
    end
  end

  always @(negedge clk) begin
    if (!rst && fetch_valid_o && fetch_ready_i) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_word: got addr=%h data=%h, required no word", fetch_addr_o, fetch_rdata_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if (fetch_addr_o !== e.a || fetch_rdata_o !== e.d || fetch_err_o !== e.e) begin
          nfail++;
          $display("FAIL fetch_word: got addr=%h data=%h err=%b, required addr=%h data=%h err=%b",
                   fetch_addr_o, fetch_rdata_o, fetch_err_o, e.a, e.d, e.e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic exp_push(input logic [31:0] a, input logic e);
    exp_q.push_back('{a: a, d: mem_word(a), e: e});
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_i = 1'b1;
    branch_addr_i = a;
    tick();
    branch_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    fetch_ready_i = 1'b0;
    if (exp_q.size() != 0) begin
      nvec++;
      nfail++;
      $display("FAIL %s_drain: got %0d words left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic quiesce(input string name);
    int n = 0;
    req_i = 1'b0;
    fetch_ready_i = 1'b0;
    while (busy_o && n < 100) begin
      tick();
      n++;
    end
    if (busy_o) begin
      nvec++;
      nfail++;
      $display("FAIL %s_quiesce: got busy=1, required 0", name);
    end
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    fetch_ready_i = 1'b0; instr_gnt_i = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_fetch_valid", 32'(fetch_valid_o), 32'h0);
    chk("rst_fetch_rdata", fetch_rdata_o, 32'h0);
    chk("rst_fetch_addr",  fetch_addr_o, 32'h0);
    chk("rst_fetch_err",   32'(fetch_err_o), 32'h0);
    chk("rst_instr_req",   32'(instr_req_o), 32'h0);
    chk("rst_instr_addr",  instr_addr_o, 32'h0);
    chk("rst_busy",        32'(busy_o), 32'h0);
    chk("rst_occupancy",   32'(occupancy_o), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Streaming: low address bits of the target are ignored, one word per cycle.
    exp_push(32'h100, 1'b0); exp_push(32'h104, 1'b0); exp_push(32'h108, 1'b0);
    pop_cyc.delete();
    instr_gnt_i = 1'b1; fetch_ready_i = 1'b1; req_i = 1'b1;
    do_branch(32'h103);
    drain("t1");
    if (pop_cyc.size() >= 3) chk("t1_stream_cycles", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);
    else chk("t1_pop_count", 32'(pop_cyc.size()), 32'd3);

    // Back-pressure: credits stop requests at DEPTH entries.
    quiesce("t2");
    req_i = 1'b1;
    do_branch(32'h1000);
    glog.delete();
    repeat (20) tick();
    chk("t2_grants", 32'(glog.size()), 32'd4);
    chk("t2_req_low", 32'(instr_req_o), 32'h0);
    chk("t2_occupancy", 32'(occupancy_o), 32'd4);
    for (int i = 0; i < 6; i++) exp_push(32'h1000 + 32'(4 * i), 1'b0);
    fetch_ready_i = 1'b1;
    drain("t2");

    // Branch while two requests are outstanding: both responses dropped.
    quiesce("t3");
    hold = 1'b1;
    exp_push(32'h400, 1'b0); exp_push(32'h404, 1'b0); exp_push(32'h408, 1'b0);
    fetch_ready_i = 1'b1; req_i = 1'b1;
    do_branch(32'h200);
    glog.delete();
    repeat (6) tick();
    chk("t3_grants", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("t3_grant0", glog[0], 32'h200);
      chk("t3_grant1", glog[1], 32'h204);
    end
    chk("t3_busy", 32'(busy_o), 32'h1);
    do_branch(32'h400);
    hold = 1'b0;
    drain("t3");
    if (glog.size() >= 3) chk("t3_grant2", glog[2], 32'h400);

    // Branch while a request waits for grant: request held stable, then target fetched.
    quiesce("t4");
    instr_gnt_i = 1'b0;
    exp_push(32'h500, 1'b0); exp_push(32'h504, 1'b0);
    fetch_ready_i = 1'b1; req_i = 1'b1;
    do_branch(32'h300);
    for (int n = 0; n < 10 && !instr_req_o; n++) tick();
    chk("t4_req_c0", 32'(instr_req_o), 32'h1);
    chk("t4_addr_c0", instr_addr_o, 32'h300);
    do_branch(32'h500);
    chk("t4_req_c1", 32'(instr_req_o), 32'h1);
    chk("t4_addr_c1", instr_addr_o, 32'h300);
    tick();
    chk("t4_addr_c2", instr_addr_o, 32'h300);
    tick();
    chk("t4_addr_c3", instr_addr_o, 32'h300);
    glog.delete();
    instr_gnt_i = 1'b1;
    drain("t4");
    chk("t4_ngrants_ge2", 32'(glog.size() >= 2), 32'h1);
    if (glog.size() >= 2) begin
      chk("t4_grant0", glog[0], 32'h300);
      chk("t4_grant1", glog[1], 32'h500);
    end

    // Address wrap at the top of the address space.
    quiesce("t5");
    exp_push(32'hFFFF_FFF8, 1'b0); exp_push(32'hFFFF_FFFC, 1'b0); exp_push(32'h0000_0000, 1'b0);
    fetch_ready_i = 1'b1; req_i = 1'b1;
    do_branch(32'hFFFF_FFF8);
    drain("t5");

    // Bus error on the word at 0x600.
    quiesce("t6");
    err_addr = 32'h600;
`ifdef CV32E41P_FETCH_ERR_EN
    exp_push(32'h600, 1'b1); exp_push(32'h604, 1'b0);
`else
    exp_push(32'h600, 1'b0); exp_push(32'h604, 1'b0); exp_push(32'h608, 1'b0);
`endif
    fetch_ready_i = 1'b1; req_i = 1'b1;
    do_branch(32'h600);
    glog.delete();
    drain("t6");
    repeat (8) tick();
`ifdef CV32E41P_FETCH_ERR_EN
    chk("t6_req_stalled", 32'(instr_req_o), 32'h0);
    chk("t6_grants", 32'(glog.size()), 32'd2);
    exp_push(32'h700, 1'b0);
    fetch_ready_i = 1'b1;
    do_branch(32'h700);
    drain("t6b");
`else
    chk("t6_fetch_continues", 32'(glog.size() >= 4), 32'h1);
`endif
    err_addr = 32'h1;

    // Reset in the middle of traffic.
    fetch_ready_i = 1'b0; req_i = 1'b1; instr_gnt_i = 1'b1;
    do_branch(32'h800);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_fetch_valid", 32'(fetch_valid_o), 32'h0);
    chk("mrst_instr_req",   32'(instr_req_o), 32'h0);
    chk("mrst_instr_addr",  instr_addr_o, 32'h0);
    chk("mrst_busy",        32'(busy_o), 32'h0);
    chk("mrst_occupancy",   32'(occupancy_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
